// File: rtl/ysyx_040066_trap_pkg.sv
// Shared definitions for the trap sequencer.
//   - trap_state_e    : FSM state encoding of ysyx_040066_trap_ctrl
//   - IrqTimerCause   : mcause value for the machine timer interrupt
//   - ExcEcall/...    : synchronous exception codes produced by the pipeline
package ysyx_040066_trap_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StTrap,
        StRet,
        StWait
    } trap_state_e;

    localparam logic [63:0] IrqTimerCause = 64'h8000_0000_0000_0007;

    localparam logic [3:0] ExcEcall   = 4'd11;
    localparam logic [3:0] ExcEbreak  = 4'd3;
    localparam logic [3:0] ExcIllegal = 4'd2;

endpackage

// File: rtl/ysyx_040066_trap_ctrl.sv
// Trap sequencer between writeback and the CSR file. Converts committed
// synchronous exceptions, mret and the CLINT timer interrupt into one-cycle
// raise_intr / ret pulses, and flushes/holds the front end around them.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid                 an instruction commits this cycle
//   wb_pc, wb_next_pc        PC of the committing instruction and its successor
//   wb_exc, wb_exc_code      committing instruction raises an exception, its cause
//   wb_tval                  exception tval
//   wb_mret                  committing instruction is mret
//   irq_timer                CLINT timer level
//   csr_mstatus_mie          mstatus.MIE
//   csr_mie_mtie             mie.MTIE
//   pipe_empty               IF..MEM hold no valid instruction
//   fetch_pc                 PC the fetch stage would fetch next
//   raise_intr               trap pulse to the CSR
//   trap_no/trap_tval/trap_pc  mcause / mtval / mepc values (registered)
//   ret                      mret pulse to the CSR
//   clear_mip                clear mip.MTIP pulse (falling edge of irq_timer)
//   flush                    kill IF..MEM contents
//   fetch_hold               freeze fetch
//   busy                     FSM not idle
module ysyx_040066_trap_ctrl
    import ysyx_040066_trap_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned REDIR_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [XLEN-1:0] wb_next_pc,
    input  logic            wb_exc,
    input  logic [3:0]      wb_exc_code,
    input  logic [XLEN-1:0] wb_tval,
    input  logic            wb_mret,

    input  logic            irq_timer,
    input  logic            csr_mstatus_mie,
    input  logic            csr_mie_mtie,

    input  logic            pipe_empty,
    input  logic [XLEN-1:0] fetch_pc,

    output logic            raise_intr,
    output logic [XLEN-1:0] trap_no,
    output logic [XLEN-1:0] trap_tval,
    output logic [XLEN-1:0] trap_pc,
    output logic            ret,
    output logic            clear_mip,
    output logic            flush,
    output logic            fetch_hold,
    output logic            busy
);

    // WAIT lasts REDIR_CYC cycles: load REDIR_CYC-1 and leave when it hits 0.
    localparam logic [3:0] RedirLoad = 4'(REDIR_CYC - 1);

    trap_state_e     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] trap_no_q, trap_no_d;
    logic [XLEN-1:0] trap_tval_q, trap_tval_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic            irq_q;

    logic irq_pend;
    logic commit_exc;
    logic commit_mret;

    assign irq_pend    = irq_timer & csr_mstatus_mie & csr_mie_mtie;
    assign commit_exc  = wb_valid & wb_exc;
    // An instruction that faults never retires as mret.
    assign commit_mret = wb_valid & wb_mret & ~wb_exc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trap_no_d   = trap_no_q;
        trap_tval_d = trap_tval_q;
        trap_pc_d   = trap_pc_q;
        flush       = 1'b0;
        fetch_hold  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (commit_exc) begin
                    trap_no_d   = {{(XLEN-4){1'b0}}, wb_exc_code};
                    trap_tval_d = wb_tval;
                    trap_pc_d   = wb_pc;
                    flush       = 1'b1;
                    fetch_hold  = 1'b1;
                    state_d     = StTrap;
                end else if (commit_mret) begin
                    flush       = 1'b1;
                    fetch_hold  = 1'b1;
                    state_d     = StRet;
                end else if (irq_pend) begin
                    state_d     = StDrain;
                end
            end

            StDrain: begin
                fetch_hold = 1'b1;
                // Committing exceptions/mret must never be lost, so they win over
                // the interrupt being withdrawn; the interrupt is re-checked in IDLE.
                if (commit_exc) begin
                    trap_no_d   = {{(XLEN-4){1'b0}}, wb_exc_code};
                    trap_tval_d = wb_tval;
                    trap_pc_d   = wb_pc;
                    flush       = 1'b1;
                    state_d     = StTrap;
                end else if (commit_mret) begin
                    flush       = 1'b1;
                    state_d     = StRet;
                end else if (!irq_pend) begin
                    state_d     = StIdle;
                end else if (wb_valid) begin
                    // Plain commit: resume after it, younger work is flushed.
                    trap_no_d   = IrqTimerCause[XLEN-1:0];
                    trap_tval_d = '0;
                    trap_pc_d   = wb_next_pc;
                    flush       = 1'b1;
                    state_d     = StTrap;
                end else if (pipe_empty) begin
                    // Nothing in flight: resume at the held fetch PC.
                    trap_no_d   = IrqTimerCause[XLEN-1:0];
                    trap_tval_d = '0;
                    trap_pc_d   = fetch_pc;
                    flush       = 1'b1;
                    state_d     = StTrap;
                end
            end

            StTrap: begin
                flush      = 1'b1;
                fetch_hold = 1'b1;
                cnt_d      = RedirLoad;
                state_d    = StWait;
            end

            StRet: begin
                flush      = 1'b1;
                fetch_hold = 1'b1;
                cnt_d      = RedirLoad;
                state_d    = StWait;
            end

            StWait: begin
                fetch_hold = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            trap_no_q   <= '0;
            trap_tval_q <= '0;
            trap_pc_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trap_no_q   <= trap_no_d;
            trap_tval_q <= trap_tval_d;
            trap_pc_q   <= trap_pc_d;
            irq_q       <= irq_timer;
        end
    end

    assign raise_intr = (state_q == StTrap);
    assign ret        = (state_q == StRet);
    assign busy       = (state_q != StIdle);
    assign clear_mip  = irq_q & ~irq_timer;
    assign trap_no    = trap_no_q;
    assign trap_tval  = trap_tval_q;
    assign trap_pc    = trap_pc_q;

endmodule

// File: tb/tb_ysyx_040066_trap_ctrl.sv
// Directed self-checking bench for ysyx_040066_trap_ctrl (REDIR_CYC = 2).
// Control outputs are checked as one vector:
//   ctrl = {raise_intr, ret, clear_mip, flush, fetch_hold, busy}
module tb_ysyx_040066_trap_ctrl;
    import ysyx_040066_trap_pkg::*;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst;
    logic            wb_valid;
    logic [XLEN-1:0] wb_pc;
    logic [XLEN-1:0] wb_next_pc;
    logic            wb_exc;
    logic [3:0]      wb_exc_code;
    logic [XLEN-1:0] wb_tval;
    logic            wb_mret;
    logic            irq_timer;
    logic            csr_mstatus_mie;
    logic            csr_mie_mtie;
    logic            pipe_empty;
    logic [XLEN-1:0] fetch_pc;
    logic            raise_intr;
    logic [XLEN-1:0] trap_no;
    logic [XLEN-1:0] trap_tval;
    logic [XLEN-1:0] trap_pc;
    logic            ret;
    logic            clear_mip;
    logic            flush;
    logic            fetch_hold;
    logic            busy;

    logic [5:0] ctrl;
    assign ctrl = {raise_intr, ret, clear_mip, flush, fetch_hold, busy};

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_040066_trap_ctrl #(
        .XLEN      (XLEN),
        .REDIR_CYC (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_valid        (wb_valid),
        .wb_pc           (wb_pc),
        .wb_next_pc      (wb_next_pc),
        .wb_exc          (wb_exc),
        .wb_exc_code     (wb_exc_code),
        .wb_tval         (wb_tval),
        .wb_mret         (wb_mret),
        .irq_timer       (irq_timer),
        .csr_mstatus_mie (csr_mstatus_mie),
        .csr_mie_mtie    (csr_mie_mtie),
        .pipe_empty      (pipe_empty),
        .fetch_pc        (fetch_pc),
        .raise_intr      (raise_intr),
        .trap_no         (trap_no),
        .trap_tval       (trap_tval),
        .trap_pc         (trap_pc),
        .ret             (ret),
        .clear_mip       (clear_mip),
        .flush           (flush),
        .fetch_hold      (fetch_hold),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid   = 1'b0;
        wb_exc     = 1'b0;
        wb_mret    = 1'b0;
        pipe_empty = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        wb_pc           = '0;
        wb_next_pc      = '0;
        wb_exc_code     = '0;
        wb_tval         = '0;
        fetch_pc        = '0;
        irq_timer       = 1'b0;
        csr_mstatus_mie = 1'b0;
        csr_mie_mtie    = 1'b0;
        clear_wb();
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want %b", ctrl, 6'b000000);
        end
        n_assert++;
        if ({trap_no, trap_tval, trap_pc} !== {3 * XLEN{1'b0}}) begin
            n_fail++;
            $display("FAIL reset_trap_regs got no=%h tval=%h pc=%h want all 0",
                     trap_no, trap_tval, trap_pc);
        end
    endtask

    task automatic test_ecall();
        tick();
        wb_valid    = 1'b1;
        wb_exc      = 1'b1;
        wb_exc_code = ExcEcall;
        wb_pc       = 64'h8000_0010;
        wb_tval     = 64'h1234;
        #1;
        n_assert++;
        if (ctrl !== 6'b000110) begin
            n_fail++;
            $display("FAIL ecall_detect ctrl got %b want %b", ctrl, 6'b000110);
        end
        tick();
        clear_wb();
        #1;
        n_assert++;
        if (ctrl !== 6'b100111) begin
            n_fail++;
            $display("FAIL ecall_trap ctrl got %b want %b", ctrl, 6'b100111);
        end
        n_assert++;
        if ({trap_no, trap_tval, trap_pc} !== {64'd11, 64'h1234, 64'h8000_0010}) begin
            n_fail++;
            $display("FAIL ecall_regs got no=%h tval=%h pc=%h want 11/1234/80000010",
                     trap_no, trap_tval, trap_pc);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_assert++;
            if (ctrl !== 6'b000011) begin
                n_fail++;
                $display("FAIL ecall_wait%0d ctrl got %b want %b", i, ctrl, 6'b000011);
            end
        end
        tick();
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL ecall_release ctrl got %b want %b", ctrl, 6'b000000);
        end
        n_assert++;
        if (trap_no !== 64'd11) begin
            n_fail++;
            $display("FAIL ecall_hold_no got %h want %h", trap_no, 64'd11);
        end
    endtask

    task automatic test_mret();
        wb_valid = 1'b1;
        wb_mret  = 1'b1;
        wb_pc    = 64'h8000_0500;
        #1;
        n_assert++;
        if (ctrl !== 6'b000110) begin
            n_fail++;
            $display("FAIL mret_detect ctrl got %b want %b", ctrl, 6'b000110);
        end
        tick();
        clear_wb();
        #1;
        n_assert++;
        if (ctrl !== 6'b010111) begin
            n_fail++;
            $display("FAIL mret_pulse ctrl got %b want %b", ctrl, 6'b010111);
        end
        n_assert++;
        if (trap_pc !== 64'h8000_0010) begin
            n_fail++;
            $display("FAIL mret_keeps_pc got %h want %h", trap_pc, 64'h8000_0010);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_assert++;
            if (ctrl !== 6'b000011) begin
                n_fail++;
                $display("FAIL mret_wait%0d ctrl got %b want %b", i, ctrl, 6'b000011);
            end
        end
        tick();
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL mret_release ctrl got %b want %b", ctrl, 6'b000000);
        end
    endtask

    task automatic test_timer_irq();
        irq_timer       = 1'b1;
        csr_mstatus_mie = 1'b1;
        csr_mie_mtie    = 1'b1;
        #1;
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL irq_detect ctrl got %b want %b", ctrl, 6'b000000);
        end
        tick();
        n_assert++;
        if (ctrl !== 6'b000011) begin
            n_fail++;
            $display("FAIL irq_drain ctrl got %b want %b", ctrl, 6'b000011);
        end
        wb_valid   = 1'b1;
        wb_pc      = 64'h8000_0100;
        wb_next_pc = 64'h8000_0104;
        #1;
        n_assert++;
        if (ctrl !== 6'b000111) begin
            n_fail++;
            $display("FAIL irq_commit ctrl got %b want %b", ctrl, 6'b000111);
        end
        tick();
        clear_wb();
        #1;
        n_assert++;
        if (ctrl !== 6'b100111) begin
            n_fail++;
            $display("FAIL irq_trap ctrl got %b want %b", ctrl, 6'b100111);
        end
        n_assert++;
        if ({trap_no, trap_tval, trap_pc} !== {IrqTimerCause, 64'd0, 64'h8000_0104}) begin
            n_fail++;
            $display("FAIL irq_regs got no=%h tval=%h pc=%h want 8000000000000007/0/80000104",
                     trap_no, trap_tval, trap_pc);
        end
        tick();
        tick();
        tick();
        // Back in IDLE; timer falls before the interrupt is seen again.
        irq_timer = 1'b0;
        #1;
        n_assert++;
        if (ctrl !== 6'b001000) begin
            n_fail++;
            $display("FAIL irq_clear_mip ctrl got %b want %b", ctrl, 6'b001000);
        end
        tick();
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL irq_clear_mip_once ctrl got %b want %b", ctrl, 6'b000000);
        end
    endtask

    task automatic test_masked_in_drain();
        irq_timer = 1'b1;
        tick();
        n_assert++;
        if (ctrl !== 6'b000011) begin
            n_fail++;
            $display("FAIL mask_drain ctrl got %b want %b", ctrl, 6'b000011);
        end
        csr_mstatus_mie = 1'b0;
        tick();
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL mask_abandon ctrl got %b want %b", ctrl, 6'b000000);
        end
        tick();
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL mask_no_trap ctrl got %b want %b", ctrl, 6'b000000);
        end
        irq_timer = 1'b0;
        #1;
        n_assert++;
        if (ctrl !== 6'b001000) begin
            n_fail++;
            $display("FAIL mask_clear_mip ctrl got %b want %b", ctrl, 6'b001000);
        end
        tick();
        n_assert++;
        if (clear_mip !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_clear_mip_once got %b want 0", clear_mip);
        end
    endtask

    task automatic test_drain_empty();
        csr_mstatus_mie = 1'b1;
        irq_timer       = 1'b1;
        tick();
        pipe_empty = 1'b1;
        fetch_pc   = 64'h8000_0200;
        #1;
        n_assert++;
        if (ctrl !== 6'b000111) begin
            n_fail++;
            $display("FAIL empty_flush ctrl got %b want %b", ctrl, 6'b000111);
        end
        tick();
        clear_wb();
        // Timer falls while the trap pulse is out: clear_mip is state-independent.
        irq_timer = 1'b0;
        #1;
        n_assert++;
        if (ctrl !== 6'b101111) begin
            n_fail++;
            $display("FAIL empty_trap ctrl got %b want %b", ctrl, 6'b101111);
        end
        n_assert++;
        if ({trap_no, trap_pc} !== {IrqTimerCause, 64'h8000_0200}) begin
            n_fail++;
            $display("FAIL empty_regs got no=%h pc=%h want 8000000000000007/80000200",
                     trap_no, trap_pc);
        end
        tick();
        tick();
        tick();
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL empty_release ctrl got %b want %b", ctrl, 6'b000000);
        end
    endtask

    task automatic test_drain_collision();
        irq_timer = 1'b1;
        tick();
        wb_valid    = 1'b1;
        wb_exc      = 1'b1;
        wb_exc_code = ExcIllegal;
        wb_pc       = 64'h8000_0300;
        wb_next_pc  = 64'h8000_0304;
        wb_tval     = 64'hdead;
        #1;
        n_assert++;
        if (ctrl !== 6'b000111) begin
            n_fail++;
            $display("FAIL coll_flush ctrl got %b want %b", ctrl, 6'b000111);
        end
        tick();
        clear_wb();
        #1;
        n_assert++;
        if ({trap_no, trap_tval, trap_pc} !== {64'd2, 64'hdead, 64'h8000_0300}) begin
            n_fail++;
            $display("FAIL coll_regs got no=%h tval=%h pc=%h want 2/dead/80000300",
                     trap_no, trap_tval, trap_pc);
        end
        tick();
        tick();
        tick();
        // Interrupt still pending: re-detected in IDLE, drained again.
        tick();
        n_assert++;
        if (ctrl !== 6'b000011) begin
            n_fail++;
            $display("FAIL coll_redrain ctrl got %b want %b", ctrl, 6'b000011);
        end
        wb_valid   = 1'b1;
        wb_next_pc = 64'h8000_0308;
        tick();
        clear_wb();
        #1;
        n_assert++;
        if ({raise_intr, trap_no, trap_pc} !== {1'b1, IrqTimerCause, 64'h8000_0308}) begin
            n_fail++;
            $display("FAIL coll_irq got ri=%b no=%h pc=%h want 1/8000000000000007/80000308",
                     raise_intr, trap_no, trap_pc);
        end
        irq_timer       = 1'b0;
        csr_mstatus_mie = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_priority();
        // exc and mret together: the exception wins, no ret pulse.
        wb_valid    = 1'b1;
        wb_exc      = 1'b1;
        wb_mret     = 1'b1;
        wb_exc_code = ExcEbreak;
        wb_pc       = 64'h8000_0400;
        wb_tval     = 64'h0;
        tick();
        clear_wb();
        #1;
        n_assert++;
        if ({ctrl, trap_no[3:0]} !== {6'b100111, 4'd3}) begin
            n_fail++;
            $display("FAIL prio_exc ctrl/code got %b/%0d want 100111/3", ctrl, trap_no[3:0]);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        // Reset while in TRAP.
        wb_valid    = 1'b1;
        wb_exc      = 1'b1;
        wb_exc_code = ExcEcall;
        wb_pc       = 64'h8000_0600;
        wb_tval     = 64'h77;
        tick();
        clear_wb();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_assert++;
        if ({ctrl, trap_no, trap_tval, trap_pc} !== {6'b000000, {3 * XLEN{1'b0}}}) begin
            n_fail++;
            $display("FAIL rst_trap got ctrl=%b no=%h tval=%h pc=%h want all 0",
                     ctrl, trap_no, trap_tval, trap_pc);
        end
        tick();
        n_assert++;
        if (ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL rst_trap_after ctrl got %b want %b", ctrl, 6'b000000);
        end
        // Reset while in WAIT.
        wb_valid = 1'b1;
        wb_exc   = 1'b1;
        tick();
        clear_wb();
        tick();
        n_assert++;
        if (ctrl !== 6'b000011) begin
            n_fail++;
            $display("FAIL rst_wait_pre ctrl got %b want %b", ctrl, 6'b000011);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_assert++;
        if ({ctrl, trap_no, trap_pc} !== {6'b000000, {2 * XLEN{1'b0}}}) begin
            n_fail++;
            $display("FAIL rst_wait got ctrl=%b no=%h pc=%h want all 0", ctrl, trap_no, trap_pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_assert++;
            if (ctrl !== 6'b000000) begin
                n_fail++;
                $display("FAIL rst_wait_after%0d ctrl got %b want %b", i, ctrl, 6'b000000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_timer_irq();
        test_masked_in_drain();
        test_drain_empty();
        test_drain_collision();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
